vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator: successor to the fixed 640x480 vga_ctrl.

---
 rtl/vga_timing_if.sv | 27 ++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Pixel-side bundle of the VGA timing generator: source data in, sync/video/request out.
// The master modport is the timing generator; the slave is the pixel source plus DAC side.
interface vga_timing_if #(
   parameter int DATA_W = 16,
   parameter int XY_W   = 10
);
   logic [DATA_W-1:0] pix_data;
   logic              hsync;
   logic              vsync;
   logic              de;
   logic              pix_req;
   logic [XY_W-1:0]   pix_x;
   logic [XY_W-1:0]   pix_y;
   logic [DATA_W-1:0] rgb;
   logic              frame_start;
   logic              line_end;

   modport master (
      input  pix_data,
      output hsync, vsync, de, pix_req, pix_x, pix_y, rgb, frame_start, line_end
   );

   modport slave (
      output pix_data,
      input  hsync, vsync, de, pix_req, pix_x, pix_y, rgb, frame_start, line_end
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, sync/de decode, early pixel
// requests with coordinates, and frame/line markers; all outputs except rgb registered.
module vga_timing_gen #(
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int H_VALID  = 640,
   parameter int H_FRONT  = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int V_VALID  = 480,
   parameter int V_FRONT  = 10,
   parameter int DATA_W   = 16,
   parameter int XY_W     = 10,
   parameter int REQ_LEAD = 1,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic         vga_clk,
   input  logic         rst_n,
   vga_timing_if.master vga
);
   localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
   // One extra code so the exclusive upper bounds below still fit when a front porch is 0.
   localparam int H_W = $clog2(H_TOTAL + 1);
   localparam int V_W = $clog2(V_TOTAL + 1);

   localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] HS_END   = H_W'(H_SYNC);
   localparam logic [H_W-1:0] DE_BEG   = H_W'(H_SYNC + H_BACK);
   localparam logic [H_W-1:0] DE_END   = H_W'(H_SYNC + H_BACK + H_VALID);
   localparam logic [H_W-1:0] REQ_BEG  = H_W'(H_SYNC + H_BACK - REQ_LEAD);
   localparam logic [H_W-1:0] REQ_END  = H_W'(H_SYNC + H_BACK + H_VALID - REQ_LEAD);
   localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] VS_END   = V_W'(V_SYNC);
   localparam logic [V_W-1:0] ACT_BEG  = V_W'(V_SYNC + V_BACK);
   localparam logic [V_W-1:0] ACT_END  = V_W'(V_SYNC + V_BACK + V_VALID);

   logic [H_W-1:0]  h_q, h_d;
   logic [V_W-1:0]  v_q, v_d;
   logic            hsync_q, hsync_d;
   logic            vsync_q, vsync_d;
   logic            de_q, de_d;
   logic            req_q, req_d;
   logic            fs_q, fs_d;
   logic            le_q, le_d;
   logic [XY_W-1:0] pix_x_q, pix_x_d;
   logic [XY_W-1:0] pix_y_q, pix_y_d;
   logic            act_line;

   // Outputs are decoded from the next position so the registers line up with (h_q, v_q).
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch can be inferred.
      h_d = h_q + H_W'(1);
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
      end

      act_line = (v_d >= ACT_BEG) && (v_d < ACT_END);
      hsync_d  = (h_d < HS_END) ? HS_POL : ~HS_POL;
      vsync_d  = (v_d < VS_END) ? VS_POL : ~VS_POL;
      de_d     = act_line && (h_d >= DE_BEG) && (h_d < DE_END);
      req_d    = act_line && (h_d >= REQ_BEG) && (h_d < REQ_END);
      pix_x_d  = req_d ? XY_W'(h_d - REQ_BEG) : '1;
      pix_y_d  = req_d ? XY_W'(v_d - ACT_BEG) : '1;
      fs_d     = (h_d == '0) && (v_d == '0);
      le_d     = (h_d == H_LAST);
   end

   // Reset values equal the h=0,v=0 decode, so the raster restarts without a partial line.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q     <= '0;
         v_q     <= '0;
         hsync_q <= HS_POL;
         vsync_q <= VS_POL;
         de_q    <= 1'b0;
         req_q   <= 1'b0;
         pix_x_q <= '1;
         pix_y_q <= '1;
         fs_q    <= 1'b1;
         le_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep all state updates on the same clock edge.
         h_q     <= h_d;
         v_q     <= v_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         req_q   <= req_d;
         pix_x_q <= pix_x_d;
         pix_y_q <= pix_y_d;
         fs_q    <= fs_d;
         le_q    <= le_d;
      end
   end

   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.de          = de_q;
   assign vga.pix_req     = req_q;
   assign vga.pix_x       = pix_x_q;
   assign vga.pix_y       = pix_y_q;
   assign vga.frame_start = fs_q;
   assign vga.line_end    = le_q;
   assign vga.rgb         = de_q ? vga.pix_data : {DATA_W{1'b0}};
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance checked over 36 lines and a tiny
// raster (17x10, REQ_LEAD=3, active-high hsync) checked over frames and a mid-frame reset.
module tb_vga_timing_gen;
   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic rst_a_n, rst_b_n;
   logic src_const_b;
   logic b_rst_done, done_b;
   int   n_cmp = 0;
   int   n_mis = 0;
   int   pos_a, pos_b;

   vga_timing_if #(.DATA_W(16), .XY_W(10)) if_a ();
   vga_timing_if #(.DATA_W(16), .XY_W(10)) if_b ();

   vga_timing_gen dut_a (
      .vga_clk (clk),
      .rst_n   (rst_a_n),
      .vga     (if_a)
   );

   vga_timing_gen #(
      .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
      .V_SYNC(2), .V_BACK(2), .V_VALID(5), .V_FRONT(1),
      .DATA_W(16), .XY_W(10), .REQ_LEAD(3), .HS_POL(1'b1), .VS_POL(1'b0)
   ) dut_b (
      .vga_clk (clk),
      .rst_n   (rst_b_n),
      .vga     (if_b)
   );

   // Pixel sources: a registered ROM for A, a 3-deep pipe (or constant white) for B.
   logic [15:0] pipe_b [3];
   always @(posedge clk) if_a.pix_data <= {if_a.pix_y[5:0], if_a.pix_x[9:0]};
   always @(posedge clk) begin
      pipe_b[0] <= {if_b.pix_y[5:0], if_b.pix_x[9:0]};
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign if_b.pix_data = src_const_b ? 16'hFFFF : pipe_b[2];

   // Raster position = clocks since reset release.
   always @(posedge clk or negedge rst_a_n) if (!rst_a_n) pos_a <= 0; else pos_a <= pos_a + 1;
   always @(posedge clk or negedge rst_b_n) if (!rst_b_n) pos_b <= 0; else pos_b <= pos_b + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Packed {hs,vs,de,req,fs,le,x[10],y[10],rgb[16]} from raster arithmetic on pos.
   function automatic logic [41:0] expect_out(input int pos, input bit is_b, input bit src_const);
      int hsw, hb, hv, hf, vsw, vb, vv, vf, lead;
      int ht, vt, h, v, hs0, v0, px, py;
      bit hp, vp, act, de, req;
      logic [9:0]  x, y;
      logic [15:0] rgb;
      if (is_b) begin
         hsw = 4;  hb = 3;  hv = 8;   hf = 2;  vsw = 2; vb = 2;  vv = 5;   vf = 1;  lead = 3;
         hp = 1'b1; vp = 1'b0;
      end else begin
         hsw = 96; hb = 48; hv = 640; hf = 16; vsw = 2; vb = 33; vv = 480; vf = 10; lead = 1;
         hp = 1'b0; vp = 1'b0;
      end
      ht  = hsw + hb + hv + hf;
      vt  = vsw + vb + vv + vf;
      h   = pos % ht;
      v   = (pos / ht) % vt;
      hs0 = hsw + hb;
      v0  = vsw + vb;
      act = (v >= v0) && (v < v0 + vv);
      de  = act && (h >= hs0) && (h < hs0 + hv);
      req = act && (h >= hs0 - lead) && (h < hs0 + hv - lead);
      x   = req ? 10'(h - hs0 + lead) : 10'h3FF;
      y   = req ? 10'(v - v0) : 10'h3FF;
      px  = h - hs0;
      py  = v - v0;
      if (!de)           rgb = 16'h0000;
      else if (src_const) rgb = 16'hFFFF;
      else               rgb = {py[5:0], px[9:0]};
      return {(h < hsw) ? hp : ~hp, (v < vsw) ? vp : ~vp, de, req,
              (h == 0) && (v == 0), h == ht - 1, x, y, rgb};
   endfunction

   // Per-cycle comparison against the model, plus statistics for the literal checks.
   int a_hs_low = 0, a_hs_high = 0, a_req34 = 0, a_de34 = 0;
   int a_req_first = -1, a_req_last = -1, a_de_first = -1, a_de_last = -1;
   int a_x_first = -1, a_x_last = -1;
   int b_vs_act = 0, b_fs = 0, b_le = 0, b_rgb_ff = 0, b_rgb_other = 0;

   always @(negedge clk) begin
      int h, v;
      if (n_mis < 50)
         check($sformatf("a_cycle@%0d", pos_a),
               {if_a.hsync, if_a.vsync, if_a.de, if_a.pix_req, if_a.frame_start,
                if_a.line_end, if_a.pix_x, if_a.pix_y, if_a.rgb},
               expect_out(pos_a, 1'b0, 1'b0));
      if (n_mis < 50)
         check($sformatf("b_cycle@%0d", pos_b),
               {if_b.hsync, if_b.vsync, if_b.de, if_b.pix_req, if_b.frame_start,
                if_b.line_end, if_b.pix_x, if_b.pix_y, if_b.rgb},
               expect_out(pos_b, 1'b1, src_const_b));

      h = pos_a % 800;
      v = pos_a / 800;
      if (rst_a_n) begin
         if (v == 1) begin
            if (!if_a.hsync) a_hs_low++; else a_hs_high++;
         end
         if (v == 34) begin
            a_req34 += int'(if_a.pix_req);
            a_de34  += int'(if_a.de);
         end
         if (v == 35 && if_a.pix_req) begin
            if (a_req_first < 0) begin a_req_first = h; a_x_first = int'(if_a.pix_x); end
            a_req_last = h;
            a_x_last   = int'(if_a.pix_x);
         end
         if (v == 35 && if_a.de) begin
            if (a_de_first < 0) a_de_first = h;
            a_de_last = h;
         end
      end

      if (rst_b_n && !b_rst_done && pos_b >= 1 && pos_b <= 170) begin
         if (!if_b.vsync) b_vs_act++;
         b_fs += int'(if_b.frame_start);
         b_le += int'(if_b.line_end);
         if (if_b.rgb == 16'hFFFF) b_rgb_ff++;
         else if (if_b.rgb != 16'h0000) b_rgb_other++;
      end
   end

   // Instance B: constant-white frame, pipelined-source frame, then mid-frame reset.
   initial begin
      int cnt;
      wait (rst_b_n === 1'b1);
      for (int i = 0; i < 2000 && pos_b != 170; i++) @(negedge clk);
      #1 src_const_b = 1'b0;
      for (int i = 0; i < 2000 && pos_b != 433; i++) @(negedge clk);
      check("b_de_before_rst", if_b.de, 1'b1);
      check("b_rgb_before_rst", if_b.rgb, 16'h0401);
      #5;
      rst_b_n    = 1'b0;
      b_rst_done = 1'b1;
      #1;
      check("b_rst_hsync", if_b.hsync, 1'b1);
      check("b_rst_vsync", if_b.vsync, 1'b0);
      check("b_rst_de", if_b.de, 1'b0);
      check("b_rst_req", if_b.pix_req, 1'b0);
      check("b_rst_pix_x", if_b.pix_x, 10'h3FF);
      check("b_rst_pix_y", if_b.pix_y, 10'h3FF);
      check("b_rst_rgb", if_b.rgb, 16'h0000);
      check("b_rst_frame_start", if_b.frame_start, 1'b1);
      check("b_rst_line_end", if_b.line_end, 1'b0);
      repeat (3) @(negedge clk);
      #5 rst_b_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
         if (if_b.frame_start) break;
      end
      check("b_frame_start_after_release", cnt, 170);
      done_b = 1'b1;
   end

   initial begin
      logic [41:0] m;
      rst_a_n     = 1'b0;
      rst_b_n     = 1'b0;
      src_const_b = 1'b1;
      b_rst_done  = 1'b0;
      done_b      = 1'b0;
      #210;
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;

      // Hand-computed points that pin the model itself.
      m = expect_out(0, 1'b0, 1'b0);
      check("model_pos0_hsync", m[41], 1'b0);
      check("model_pos0_fs", m[37], 1'b1);
      m = expect_out(35 * 800 + 143, 1'b0, 1'b0);
      check("model_first_req", {m[39], m[38], m[35:26], m[25:16]}, {2'b01, 10'd0, 10'd0});
      m = expect_out(36 * 800 + 150, 1'b0, 1'b0);
      check("model_rgb_x6_y1", m[15:0], 16'h0406);
      check("model_pix_x_7", m[35:26], 10'd7);

      for (int i = 0; i < 40000 && pos_a < 36 * 800 + 5; i++) @(negedge clk);
      for (int i = 0; i < 5000 && !done_b; i++) @(negedge clk);
      check("b_sequence_done", done_b, 1'b1);

      check("a_hsync_low_clks", a_hs_low, 96);
      check("a_hsync_high_clks", a_hs_high, 704);
      check("a_line34_req", a_req34, 0);
      check("a_line34_de", a_de34, 0);
      check("a_line35_req_first_h", a_req_first, 143);
      check("a_line35_req_last_h", a_req_last, 782);
      check("a_line35_pix_x_first", a_x_first, 0);
      check("a_line35_pix_x_last", a_x_last, 639);
      check("a_line35_de_first_h", a_de_first, 144);
      check("a_line35_de_last_h", a_de_last, 783);

      check("b_vsync_active_clks", b_vs_act, 34);
      check("b_frame_start_count", b_fs, 1);
      check("b_line_end_count", b_le, 10);
      check("b_rgb_white_clks", b_rgb_ff, 40);
      check("b_rgb_other_clks", b_rgb_other, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
